// File: rtl/led_pkg.sv
//
// led_pkg -- shared definitions for the LED PWM fader.
//
// Contents:
//   MAX_CHANNELS / MIN_WIDTH / MAX_WIDTH : supported parameter ranges
//   level_t     : duty/target/step value at the widest supported resolution
//   ch_cfg_t    : per-channel configuration written by the host {target, step}
//   fade_dir_t  : which way a channel's duty is heading at the next boundary
//   fade_dir()  : classifies duty versus target
//   fade_next() : next duty value, saturating at target
//
// The optional stepped-fade feature is selected with the LED_PWM_FADE_EN
// macro. This package is identical in both builds.

package led_pkg;

    localparam int MAX_CHANNELS = 16;
    localparam int MIN_WIDTH    = 2;
    localparam int MAX_WIDTH    = 16;

    typedef logic [MAX_WIDTH-1:0] level_t;

    typedef struct packed {
        level_t target;
        level_t step;
    } ch_cfg_t;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } fade_dir_t;

    function automatic fade_dir_t fade_dir(input level_t duty, input level_t target);
        fade_dir_t dir;
        if (duty < target)
            dir = DIR_UP;
        else if (duty > target)
            dir = DIR_DOWN;
        else
            dir = DIR_HOLD;
        return dir;
    endfunction

    // Values narrower than MAX_WIDTH arrive zero-extended, so the extra
    // carry bit always has room. A zero step means "jump straight to target",
    // which is done by substituting full scale for the step.
    function automatic level_t fade_next(input fade_dir_t dir,
                                         input level_t    duty,
                                         input level_t    target,
                                         input level_t    step,
                                         input level_t    full_scale);
        logic [MAX_WIDTH:0] sum;
        logic [MAX_WIDTH:0] gap;
        level_t             eff;
        level_t             result;
        eff    = (step == '0) ? full_scale : step;
        sum    = {1'b0, duty} + {1'b0, eff};
        gap    = {1'b0, duty} - {1'b0, target};
        result = duty;
        case (dir)
            DIR_UP:   result = (sum >= {1'b0, target}) ? target : sum[MAX_WIDTH-1:0];
            DIR_DOWN: result = ({1'b0, eff} >= gap) ? target : (duty - eff);
            default:  result = duty;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
//
// led_fade_channel -- one PWM channel: stores its target (and step when
// fading is enabled), moves its duty toward the target once per PWM period
// and compares the shared period counter against duty.
//
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   boundary  : high in the last cycle of a PWM period (cnt all ones)
//   cnt       : shared free-running period counter
//   wr_sel    : this channel is being written this cycle
//   wr_cfg    : new {target, step}, zero-extended to MAX_WIDTH
//   led_out   : registered PWM output
//   busy      : registered "duty has not reached target yet"
//
// Macro LED_PWM_FADE_EN: defined -> duty moves by step per period;
// undefined -> no step register, duty jumps to target at each boundary.

module led_fade_channel
    import led_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary,
    input  logic [WIDTH-1:0] cnt,
    input  logic             wr_sel,
    input  ch_cfg_t          wr_cfg,
    output logic             led_out,
    output logic             busy
);

    localparam logic [WIDTH-1:0] FULL = '1;

    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] duty_nxt;

    // Only the low WIDTH bits of the configuration are meaningful here.
    logic unused_cfg;
    assign unused_cfg = ^wr_cfg;

`ifdef LED_PWM_FADE_EN
    logic [WIDTH-1:0] step;
    fade_dir_t        dir;

    // Host writes land on the next edge; a write in the boundary cycle is
    // therefore only seen by the following boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            target <= '0;
            step   <= '0;
        end else if (wr_sel) begin
            target <= WIDTH'(wr_cfg.target);
            step   <= WIDTH'(wr_cfg.step);
        end
    end

    // Next duty walks toward target by step and saturates at target.
    always_comb begin
        dir      = fade_dir(level_t'(duty), level_t'(target));
        duty_nxt = duty;
        if (dir != DIR_HOLD)
            duty_nxt = WIDTH'(fade_next(dir, level_t'(duty), level_t'(target),
                                        level_t'(step), level_t'(FULL)));
    end
`else
    // Without fading only the target is kept.
    always_ff @(posedge clk) begin
        if (rst)
            target <= '0;
        else if (wr_sel)
            target <= WIDTH'(wr_cfg.target);
    end

    // Duty simply follows target at each boundary.
    always_comb begin
        duty_nxt = target;
    end
`endif

    // Duty only moves at the period boundary so a whole period is drawn
    // with one constant duty.
    always_ff @(posedge clk) begin
        if (rst)
            duty <= '0;
        else if (boundary)
            duty <= duty_nxt;
    end

    // All-ones duty would otherwise drop for the cnt == max cycle; force it
    // solidly on. Zero duty is naturally never on.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_out <= 1'b0;
            busy    <= 1'b0;
        end else begin
            led_out <= (duty == FULL) || (cnt < duty);
            busy    <= (duty != target);
        end
    end

endmodule

// File: rtl/led_pwm_fade.sv
//
// led_pwm_fade -- multi-channel LED PWM generator with per-channel fading.
//
// Parameters:
//   CHANNELS : number of PWM outputs (1..16)
//   WIDTH    : counter / duty resolution in bits (2..16); period = 2^WIDTH
//   CH_W     : width of the channel select
//
// Ports:
//   clk         : sole clock, rising edge
//   rst         : synchronous active-high reset
//   wr_en       : write strobe for one channel's target/step
//   wr_ch       : channel index of the write; indices >= CHANNELS are ignored
//   wr_level    : new target duty
//   wr_step     : fade increment per period, 0 = jump
//   led_out     : registered PWM outputs, bit i = channel i
//   busy        : bit i high while channel i duty differs from its target
//   period_tick : one-cycle pulse on the last cycle of each output period
//
// Macro LED_PWM_FADE_EN: defined -> stepped fade using wr_step;
// undefined -> wr_step is ignored and duty jumps to target each boundary.

module led_pwm_fade
    import led_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_level,
    input  logic [WIDTH-1:0]    wr_step,
    output logic [CHANNELS-1:0] led_out,
    output logic [CHANNELS-1:0] busy,
    output logic                period_tick
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cnt;
    logic             boundary;
    ch_cfg_t          wr_cfg;

    assign boundary = (cnt == CNT_MAX);

    // Free-running period counter; wraps naturally from all ones to zero.
    // The tick is registered, so it lines up with the final cycle of the
    // registered led_out period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            cnt         <= cnt + 1'b1;
            period_tick <= boundary;
        end
    end

    assign wr_cfg.target = level_t'(wr_level);
`ifdef LED_PWM_FADE_EN
    assign wr_cfg.step   = level_t'(wr_step);
`else
    assign wr_cfg.step   = '0;
    logic unused_step;
    assign unused_step = ^wr_step;
`endif

    // One channel per output; the select compare rejects out-of-range
    // indices simply because no channel matches them.
    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        logic wr_sel;
        assign wr_sel = wr_en && (wr_ch == CH_W'(i));

        led_fade_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .boundary(boundary),
            .cnt     (cnt),
            .wr_sel  (wr_sel),
            .wr_cfg  (wr_cfg),
            .led_out (led_out[i]),
            .busy    (busy[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_fade.sv
//
// tb_led_pwm_fade -- self-checking bench for led_pwm_fade (CHANNELS=3,
// WIDTH=4). Each PWM period is observed as a window of 16 cycles ending on
// period_tick; per channel the number of high cycles gives the duty of that
// period (16 means solidly on). Expected windows come from a table and go
// through a scoreboard queue. Expectations follow LED_PWM_FADE_EN.

module tb_led_pwm_fade;

    localparam int CHANNELS = 3;
    localparam int WIDTH    = 4;
    localparam int CH_W     = 2;
    localparam int PERIOD   = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [WIDTH-1:0]    wr_level;
    logic [WIDTH-1:0]    wr_step;
    logic [CHANNELS-1:0] led_out;
    logic [CHANNELS-1:0] busy;
    logic                period_tick;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [4:0] hi0;
        logic [4:0] hi1;
        logic [4:0] hi2;
        logic [2:0] busy;
    } win_t;

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] level;
        logic [3:0] step;
        logic [2:0] nwin;
    } vec_t;

    vec_t vec_tab[$];
    win_t win_tab[$];
    win_t exp_q[$];
    int   win_ptr = 0;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    led_pwm_fade #(
        .CHANNELS(CHANNELS),
        .WIDTH   (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_level   (wr_level),
        .wr_step    (wr_step),
        .led_out    (led_out),
        .busy       (busy),
        .period_tick(period_tick)
    );

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic addVec(input logic [1:0] ch, input logic [3:0] lvl,
                          input logic [3:0] stp, input logic [2:0] n);
        vec_t v;
        v.ch = ch; v.level = lvl; v.step = stp; v.nwin = n;
        vec_tab.push_back(v);
    endtask

    task automatic addWin(input int h0, input int h1, input int h2, input logic [2:0] b);
        win_t w;
        w.hi0 = 5'(h0); w.hi1 = 5'(h1); w.hi2 = 5'(h2); w.busy = b;
        win_tab.push_back(w);
    endtask

    // Counts cycles until period_tick is seen, bounded.
    task automatic waitTick(input int limit, output int waited);
        waited = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (period_tick) begin
                waited = k;
                break;
            end
        end
        if (waited < 0)
            $display("[TB] FAIL wait_tick: got timeout after %0d cycles expected a tick", limit);
    endtask

    // Observe one full output period; optionally issue a write at sample wr_at.
    task automatic measureWindow(input int wr_at, input logic [1:0] ch,
                                 input logic [3:0] lvl, input logic [3:0] stp,
                                 output win_t obs, output int tick_bad);
        obs      = '0;
        tick_bad = 0;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (k == wr_at) begin
                wr_en = 1'b1; wr_ch = ch; wr_level = lvl; wr_step = stp;
            end
            obs.hi0 += 5'(led_out[0]);
            obs.hi1 += 5'(led_out[1]);
            obs.hi2 += 5'(led_out[2]);
            if ((k < PERIOD) == period_tick)
                tick_bad++;
            if (k == PERIOD)
                obs.busy = busy;
        end
        wr_en = 1'b0;
    endtask

    // Drive one table write and queue the windows it should produce.
    task automatic applyStimulus(input vec_t v);
        wr_en = 1'b1; wr_ch = v.ch; wr_level = v.level; wr_step = v.step;
        for (int j = 0; j < int'(v.nwin); j++) begin
            exp_q.push_back(win_tab[win_ptr]);
            win_ptr++;
        end
    endtask

    task automatic checkOutput(input win_t obs, input int tick_bad);
        win_t e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL scoreboard: got an output window expected none queued");
            return;
        end
        e = exp_q.pop_front();
        checkVal("hi_ch0", int'(obs.hi0), int'(e.hi0));
        checkVal("hi_ch1", int'(obs.hi1), int'(e.hi1));
        checkVal("hi_ch2", int'(obs.hi2), int'(e.hi2));
        checkVal("busy", int'(obs.busy), int'(e.busy));
        checkVal("tick_position", tick_bad, 0);
    endtask

    task automatic buildTable();
        addVec(2'd0, 4'd8, 4'd0, 3'd2);
        addWin(0, 0, 0, 3'b001); addWin(8, 0, 0, 3'b000);
        addVec(2'd1, 4'd15, 4'd4, 3'd5);
`ifdef LED_PWM_FADE_EN
        addWin(8, 0, 0, 3'b010);  addWin(8, 4, 0, 3'b010); addWin(8, 8, 0, 3'b010);
        addWin(8, 12, 0, 3'b010); addWin(8, 16, 0, 3'b000);
`else
        addWin(8, 0, 0, 3'b010);  addWin(8, 16, 0, 3'b000); addWin(8, 16, 0, 3'b000);
        addWin(8, 16, 0, 3'b000); addWin(8, 16, 0, 3'b000);
`endif
        addVec(2'd2, 4'd12, 4'd0, 3'd2);
        addWin(8, 16, 0, 3'b100); addWin(8, 16, 12, 3'b000);
        addVec(2'd2, 4'd0, 4'd5, 3'd4);
`ifdef LED_PWM_FADE_EN
        addWin(8, 16, 12, 3'b100); addWin(8, 16, 7, 3'b100);
        addWin(8, 16, 2, 3'b100);  addWin(8, 16, 0, 3'b000);
`else
        addWin(8, 16, 12, 3'b100); addWin(8, 16, 0, 3'b000);
        addWin(8, 16, 0, 3'b000);  addWin(8, 16, 0, 3'b000);
`endif
        addVec(2'd3, 4'd1, 4'd0, 3'd2);
        addWin(8, 16, 0, 3'b000); addWin(8, 16, 0, 3'b000);
        addVec(2'd0, 4'd0, 4'd3, 3'd2);
`ifdef LED_PWM_FADE_EN
        addWin(8, 16, 0, 3'b001); addWin(5, 16, 0, 3'b001);
`else
        addWin(8, 16, 0, 3'b001); addWin(0, 16, 0, 3'b000);
`endif
        addVec(2'd0, 4'd15, 4'd6, 3'd4);
`ifdef LED_PWM_FADE_EN
        addWin(2, 16, 0, 3'b001);  addWin(8, 16, 0, 3'b001);
        addWin(14, 16, 0, 3'b001); addWin(16, 16, 0, 3'b000);
`else
        addWin(0, 16, 0, 3'b001);  addWin(16, 16, 0, 3'b000);
        addWin(16, 16, 0, 3'b000); addWin(16, 16, 0, 3'b000);
`endif
    endtask

    initial begin
        win_t obs;
        int   tick_bad;
        int   waited;

        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_level = '0; wr_step = '0;
        buildTable();
        repeat (3) @(negedge clk);
        checkVal("reset_led_out", int'(led_out), 0);
        checkVal("reset_busy", int'(busy), 0);
        checkVal("reset_tick", int'(period_tick), 0);
        rst = 1'b0;
        waitTick(40, waited);
        checkVal("reset_to_first_tick", waited, PERIOD);

        $display("[TB] table vectors: %0d", vec_tab.size());
        foreach (vec_tab[v]) begin
            applyStimulus(vec_tab[v]);
            for (int j = 0; j < int'(vec_tab[v].nwin); j++) begin
                measureWindow(0, 2'd0, 4'd0, 4'd0, obs, tick_bad);
                checkOutput(obs, tick_bad);
            end
        end

        // Write ch0 to zero in the exact boundary cycle: the boundary keeps
        // the old target, the next one applies the new value.
        $display("[TB] boundary-coincident write");
        addWin(16, 16, 0, 3'b000); exp_q.push_back(win_tab[win_tab.size()-1]);
        measureWindow(PERIOD - 1, 2'd0, 4'd0, 4'd0, obs, tick_bad);
        checkOutput(obs, tick_bad);
        addWin(16, 16, 0, 3'b001); exp_q.push_back(win_tab[win_tab.size()-1]);
        measureWindow(0, 2'd0, 4'd0, 4'd0, obs, tick_bad);
        checkOutput(obs, tick_bad);
        addWin(0, 16, 0, 3'b000); exp_q.push_back(win_tab[win_tab.size()-1]);
        measureWindow(0, 2'd0, 4'd0, 4'd0, obs, tick_bad);
        checkOutput(obs, tick_bad);

        // Reset in the middle of a fade with a write pending.
        $display("[TB] mid-fade reset");
        wr_en = 1'b1; wr_ch = 2'd1; wr_level = 4'd0; wr_step = 4'd1;
        measureWindow(0, 2'd0, 4'd0, 4'd0, obs, tick_bad);
        repeat (5) @(negedge clk);
        rst = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_level = 4'd5; wr_step = 4'd0;
        @(negedge clk);
        checkVal("rst_led_out", int'(led_out), 0);
        checkVal("rst_busy", int'(busy), 0);
        checkVal("rst_tick", int'(period_tick), 0);
        rst = 1'b0; wr_en = 1'b0;
        waitTick(40, waited);
        checkVal("rst_to_tick", waited, PERIOD);
        addWin(0, 0, 0, 3'b000); exp_q.push_back(win_tab[win_tab.size()-1]);
        measureWindow(0, 2'd0, 4'd0, 4'd0, obs, tick_bad);
        checkOutput(obs, tick_bad);

        checkVal("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
